// File: rtl/modpipe_segment_select_pipe.sv
// modpipe_segment_select_pipe: picks array_ref or array_ref_m on input_bit==zero and delays it DEPTH stages
// Ports: clk, reset (async, active-high); start, input_bit, zero, array_ref, array_ref_m in;
//        segment/branch_else (selected value, held between pulses), valid pulse, busy, seg_count out.
// Optional MODPIPE_STALL_EN adds input stall: pipeline freezes, starts are dropped, valid is masked.
module modpipe_segment_select_pipe #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] input_bit,
   input  logic [WIDTH-1:0] zero,
   input  logic [WIDTH-1:0] array_ref,
   input  logic [WIDTH-1:0] array_ref_m,
   output logic [WIDTH-1:0] segment,
   output logic             branch_else,
   output logic             valid,
   output logic             busy,
   output logic [CNT_W-1:0] seg_count
`ifdef MODPIPE_STALL_EN
   ,
   input  logic             stall
`endif
);
   logic             adv;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic             e_q [DEPTH];
   logic [DEPTH-1:0] t_q;
   logic [WIDTH-1:0] seg_h;
   logic             be_h;
`ifdef MODPIPE_STALL_EN
   assign adv = ~stall;
`else
   assign adv = 1'b1;
`endif
   assign valid       = t_q[DEPTH-1] & adv;
   assign busy        = |t_q;
   // final stage is shown while it is emitted; afterwards the captured copy holds the last value
   assign segment     = valid ? d_q[DEPTH-1] : seg_h;
   assign branch_else = valid ? e_q[DEPTH-1] : be_h;
   always_ff @(posedge clk)
      if (adv) begin
         d_q[0] <= (input_bit == zero) ? array_ref : array_ref_m;
         e_q[0] <= input_bit != zero;
         for (int k = 1; k < DEPTH; k++) begin
            d_q[k] <= d_q[k-1];
            e_q[k] <= e_q[k-1];
         end
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         t_q       <= '0;
         seg_h     <= '0;
         be_h      <= 1'b0;
         seg_count <= '0;
      end else if (adv) begin
         t_q[0] <= start;
         for (int k = 1; k < DEPTH; k++) t_q[k] <= t_q[k-1];
         if (valid) begin
            seg_h     <= d_q[DEPTH-1];
            be_h      <= e_q[DEPTH-1];
            seg_count <= seg_count + 1'b1;
         end
      end
endmodule

// File: tb/tb_modpipe_segment_select_pipe.sv
// tb_modpipe_segment_select_pipe: directed vector bench over DEPTH=1/3/4(CNT_W=4)/2 instances
module tb_modpipe_segment_select_pipe;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [31:0] input_bit = '0, zero = '0, array_ref = '0, array_ref_m = '0;
`ifdef MODPIPE_STALL_EN
   logic        stall = 1'b0;
`endif
   logic [31:0] seg_a, seg_b, seg_c, seg_d;
   logic        be_a, be_b, be_c, be_d, v_a, v_b, v_c, v_d, bz_a, bz_b, bz_c, bz_d;
   logic [15:0] cnt_a, cnt_b, cnt_d;
   logic [3:0]  cnt_c;
   int          n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   modpipe_segment_select_pipe #(.WIDTH(32), .DEPTH(1), .CNT_W(16)) u_a (
      .clk(clk), .reset(reset), .start(start), .input_bit(input_bit), .zero(zero),
      .array_ref(array_ref), .array_ref_m(array_ref_m), .segment(seg_a), .branch_else(be_a),
      .valid(v_a), .busy(bz_a), .seg_count(cnt_a)
`ifdef MODPIPE_STALL_EN
      , .stall(stall)
`endif
   );
   modpipe_segment_select_pipe #(.WIDTH(32), .DEPTH(3), .CNT_W(16)) u_b (
      .clk(clk), .reset(reset), .start(start), .input_bit(input_bit), .zero(zero),
      .array_ref(array_ref), .array_ref_m(array_ref_m), .segment(seg_b), .branch_else(be_b),
      .valid(v_b), .busy(bz_b), .seg_count(cnt_b)
`ifdef MODPIPE_STALL_EN
      , .stall(stall)
`endif
   );
   modpipe_segment_select_pipe #(.WIDTH(32), .DEPTH(4), .CNT_W(4)) u_c (
      .clk(clk), .reset(reset), .start(start), .input_bit(input_bit), .zero(zero),
      .array_ref(array_ref), .array_ref_m(array_ref_m), .segment(seg_c), .branch_else(be_c),
      .valid(v_c), .busy(bz_c), .seg_count(cnt_c)
`ifdef MODPIPE_STALL_EN
      , .stall(stall)
`endif
   );
   modpipe_segment_select_pipe #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) u_d (
      .clk(clk), .reset(reset), .start(start), .input_bit(input_bit), .zero(zero),
      .array_ref(array_ref), .array_ref_m(array_ref_m), .segment(seg_d), .branch_else(be_d),
      .valid(v_d), .busy(bz_d), .seg_count(cnt_d)
`ifdef MODPIPE_STALL_EN
      , .stall(stall)
`endif
   );

   typedef struct {
      logic [31:0] ib, z, ar, arm, seg;
      logic        be;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic get(input int w, output logic [31:0] s, output logic b, output logic v,
                      output logic bz, output logic [31:0] cnt);
      s   = w == 0 ? seg_a : w == 1 ? seg_b : w == 2 ? seg_c : seg_d;
      b   = w == 0 ? be_a : w == 1 ? be_b : w == 2 ? be_c : be_d;
      v   = w == 0 ? v_a : w == 1 ? v_b : w == 2 ? v_c : v_d;
      bz  = w == 0 ? bz_a : w == 1 ? bz_b : w == 2 ? bz_c : bz_d;
      cnt = w == 0 ? 32'(cnt_a) : w == 1 ? 32'(cnt_b) : w == 2 ? 32'(cnt_c) : 32'(cnt_d);
   endtask

   task automatic do_reset();
      @(negedge clk);
      start = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // back-to-back items k=0..n-1 carrying array_ref=k; iteration c observes the state after edge c-1
   task automatic stream(input int w, input int depth, input int n, input int cw);
      logic [31:0] s, cnt;
      logic        b, v, bz;
      int          done;
      for (int c = 0; c <= depth + n + 1; c++) begin
         @(negedge clk);
         get(w, s, b, v, bz, cnt);
         done = c < depth ? 0 : (c - depth > n ? n : c - depth);
         check($sformatf("stream%0d c%0d valid", w, c), 32'(v), 32'(c >= depth && c < depth + n));
         check($sformatf("stream%0d c%0d busy", w, c), 32'(bz), 32'(c >= 1 && c < depth + n));
         check($sformatf("stream%0d c%0d seg_count", w, c), cnt, 32'(done % (1 << cw)));
         if (c >= depth && c < depth + n) check($sformatf("stream%0d c%0d segment", w, c), s, 32'(c - depth));
         if (c >= depth + n) check($sformatf("stream%0d c%0d hold", w, c), s, 32'(n - 1));
         start       = c < n;
         input_bit   = 32'(c);
         zero        = 32'(c);
         array_ref   = 32'(c);
         array_ref_m = ~32'(c);
      end
      start = 1'b0;
   endtask

   initial begin
      vec_t tbl [6];
      tbl[0] = '{ib: 32'h5,        z: 32'h5,        ar: 32'hAAAA0001, arm: 32'h55550002, seg: 32'hAAAA0001, be: 1'b0};
      tbl[1] = '{ib: 32'h6,        z: 32'h5,        ar: 32'h11111111, arm: 32'h12345678, seg: 32'h12345678, be: 1'b1};
      tbl[2] = '{ib: 32'h80000000, z: 32'h0,        ar: 32'h1,        arm: 32'h2,        seg: 32'h2,        be: 1'b1};
      tbl[3] = '{ib: 32'hFFFFFFFF, z: 32'hFFFFFFFF, ar: 32'hCAFEF00D, arm: 32'h0,        seg: 32'hCAFEF00D, be: 1'b0};
      tbl[4] = '{ib: 32'h0,        z: 32'h0,        ar: 32'h0,        arm: 32'hFFFFFFFF, seg: 32'h0,        be: 1'b0};
      tbl[5] = '{ib: 32'h0,        z: 32'h1,        ar: 32'h3,        arm: 32'h4,        seg: 32'h4,        be: 1'b1};

      // reset state
      repeat (2) @(negedge clk);
      check("rst seg_a", seg_a, 0);
      check("rst valid_a", 32'(v_a), 0);
      check("rst busy_a", 32'(bz_a), 0);
      check("rst cnt_a", 32'(cnt_a), 0);
      check("rst be_b", 32'(be_b), 0);
      check("rst cnt_c", 32'(cnt_c), 0);
      reset = 1'b0;

      // DEPTH=1 table, applied back to back
      for (int i = 0; i <= 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check($sformatf("tbl%0d valid", i - 1), 32'(v_a), 1);
            check($sformatf("tbl%0d segment", i - 1), seg_a, tbl[i-1].seg);
            check($sformatf("tbl%0d branch_else", i - 1), 32'(be_a), 32'(tbl[i-1].be));
            check($sformatf("tbl%0d busy", i - 1), 32'(bz_a), 1);
            check($sformatf("tbl%0d seg_count", i - 1), 32'(cnt_a), 32'(i - 1));
         end
         start = i < 6;
         if (i < 6) begin
            input_bit   = tbl[i].ib;
            zero        = tbl[i].z;
            array_ref   = tbl[i].ar;
            array_ref_m = tbl[i].arm;
         end
      end
      @(negedge clk);
      check("tbl end valid", 32'(v_a), 0);
      check("tbl end busy", 32'(bz_a), 0);
      check("tbl end hold", seg_a, 32'h4);
      check("tbl end be hold", 32'(be_a), 1);
      check("tbl end seg_count", 32'(cnt_a), 6);

      // else branch, DEPTH=3
      do_reset();
      @(negedge clk);
      start = 1'b1; input_bit = 32'h6; zero = 32'h5; array_ref = 32'hDEADBEEF; array_ref_m = 32'h12345678;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         check($sformatf("else c%0d valid", c), 32'(v_b), 32'(c == 3));
         check($sformatf("else c%0d busy", c), 32'(bz_b), 32'(c <= 3));
         if (c >= 3) begin
            check($sformatf("else c%0d segment", c), seg_b, 32'h12345678);
            check($sformatf("else c%0d branch_else", c), 32'(be_b), 1);
         end
         @(negedge clk);
      end

      // streaming on DEPTH=3, then 17-item counter wrap on DEPTH=4/CNT_W=4
      do_reset();
      stream(1, 3, 8, 16);
      check("stream end seg_count", 32'(cnt_b), 8);
      do_reset();
      stream(2, 4, 17, 4);
      check("wrap seg_count", 32'(cnt_c), 1);

      // reset with 3 items in flight on DEPTH=4
      @(negedge clk);
      start = 1'b1; input_bit = 32'h9; zero = 32'h9; array_ref = 32'h77;
      repeat (3) @(negedge clk);
      start = 1'b0;
      check("midrst busy before", 32'(bz_c), 1);
      reset = 1'b1;
      #1;
      check("midrst segment", seg_c, 0);
      check("midrst valid", 32'(v_c), 0);
      check("midrst busy", 32'(bz_c), 0);
      check("midrst seg_count", 32'(cnt_c), 0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check($sformatf("postrst c%0d valid", c), 32'(v_c), 0);
         check($sformatf("postrst c%0d busy", c), 32'(bz_c), 0);
      end

`ifdef MODPIPE_STALL_EN
      // DEPTH=2: two items in flight, stall for 5 cycles while offering a start that must be dropped
      do_reset();
      @(negedge clk);
      start = 1'b1; input_bit = 32'h1; zero = 32'h1; array_ref = 32'hA1;
      @(negedge clk);
      array_ref = 32'hA2;
      @(negedge clk);
      stall = 1'b1; array_ref = 32'hBAD;
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("stall c%0d valid", c), 32'(v_d), 0);
         check($sformatf("stall c%0d busy", c), 32'(bz_d), 1);
         check($sformatf("stall c%0d seg_count", c), 32'(cnt_d), 0);
         @(negedge clk);
      end
      stall = 1'b0; start = 1'b0;
      #1;
      check("unstall item0 valid", 32'(v_d), 1);
      check("unstall item0 segment", seg_d, 32'hA1);
      @(negedge clk);
      check("unstall item1 valid", 32'(v_d), 1);
      check("unstall item1 segment", seg_d, 32'hA2);
      @(negedge clk);
      check("unstall drain valid", 32'(v_d), 0);
      check("unstall drain busy", 32'(bz_d), 0);
      check("unstall seg_count", 32'(cnt_d), 2);
      @(negedge clk);
      check("unstall no dropped item", 32'(v_d), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule
